// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encodings, widths and pc helper for fetch_ctrl
package fetch_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
    return a + XLEN'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: owns the fetch pc, issues req/ack reads, hands words to decode
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] START_ADDR = '0,
  parameter int              AW         = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc_out
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [AW-1:0]   r_drop_addr;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  logic            w_mem_req;
  logic [AW-1:0]   w_mem_addr;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_mem_req     = (r_state != S_RESET);
  // A read abandoned by a redirect keeps its address until its ack drains.
  assign w_mem_addr    = (r_state == S_DROP) ? r_drop_addr : r_pc[AW+1:2];
  assign w_redirect_pc = redirect_pc & ~XLEN'(WORD_BYTES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RESET;
      r_pc         <= START_ADDR;
      r_drop_addr  <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else if (redirect) begin
      r_pc         <= w_redirect_pc;
      r_inst_valid <= 1'b0;
      if (w_mem_req && !mem_ack) begin
        r_state     <= S_DROP;
        r_drop_addr <= w_mem_addr;
      end else begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            r_inst       <= mem_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc         <= next_word(r_pc);
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Without inst_ready the prefetch ack is left for the memory to hold.
          if (inst_ready) begin
            if (mem_ack) begin
              r_inst    <= mem_data;
              r_inst_pc <= r_pc;
              r_pc      <= next_word(r_pc);
            end else begin
              r_inst_valid <= 1'b0;
              r_state      <= S_FETCH;
            end
          end
        end
        S_DROP: begin
          if (mem_ack) r_state <= S_FETCH;
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign mem_req    = w_mem_req;
  assign mem_addr   = w_mem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign pc_out     = r_pc;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the program counter and instruction memory `im`.
- Owns the fetch PC and issues word reads over a req/ack port, so `im` may be combinational (ack tied to req) or multi-cycle.
- Delivers each instruction with its PC to decode over a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that arrives while a read is outstanding.

Parameters:
- START_ADDR, 0, byte address of the first fetch after reset; word-aligned.
- AW, 7, instruction-memory word-address width; mem_addr = pc[AW+1:2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect  in  1  single-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  byte target of the redirect.
- mem_req  out  1  read request to im.
- mem_addr  out  AW  word address of the read.
- mem_ack  in  1  read data valid.
- mem_data  in  32  instruction word.
- inst_valid  out  1  inst and inst_pc are valid.
- inst  out  32  fetched instruction.
- inst_pc  out  32  byte address of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- pc_out  out  32  current fetch PC, i.e. the address being requested.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately regardless of state):
  - state=S_RESET, pc=START_ADDR.
  - mem_req=0, inst_valid=0, inst=0, inst_pc=0.
- States:
  - S_RESET: mem_req=0. Next edge -> S_FETCH.
  - S_FETCH: mem_req=1, inst_valid=0. On an edge with mem_ack=1: inst<=mem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, -> S_HOLD.
  - S_HOLD: inst_valid=1; mem_req=1 at the next pc (prefetch).
    - inst_ready=1 and mem_ack=1: load the next word as in S_FETCH; stay in S_HOLD. This gives 1 instruction/cycle with a combinational im.
    - inst_ready=1 and mem_ack=0: inst_valid<=0, -> S_FETCH; the request stays pending.
    - inst_ready=0: hold all outputs; mem_ack is ignored.
  - S_DROP: mem_req=1 at the old address, inst_valid=0. On mem_ack=1 the data is discarded, -> S_FETCH at the new pc.
- Memory contract:
  - While mem_req=1, mem_addr is stable until the edge where ack is consumed.
  - Memory holds mem_ack/mem_data stable while unconsumed (S_HOLD with inst_ready=0).
- Redirect (highest priority, any state except reset):
  - pc<=redirect_pc with bits [1:0] cleared; inst_valid<=0 (flushes any held instruction, accepted or not).
  - If mem_req=1 and mem_ack=0 at that edge (read in flight): -> S_DROP, and mem_addr stays at the old address until the dropped ack.
  - Otherwise -> S_FETCH; an ack present at that edge is discarded.
  - Redirect in S_DROP updates pc and stays in S_DROP.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000); mem_addr takes the low address bits only.
- Latency with ack tied to req:
  - first inst_valid on the 2nd rising edge after rst_n deasserts;
  - then one instruction per cycle while inst_ready=1;
  - after a redirect, the first new instruction is valid 2 edges later.
- pc_out = pc (registered), mirroring the existing pc block's pc_out.

Decomposition:
- Shared package/header:
  - state encodings S_RESET, S_FETCH, S_HOLD, S_DROP;
  - constant WORD_BYTES=4;
  - the 32-bit instruction/address width.
- No sub-module: one state register, the pc register and the output registers fit in a single module.
- Existing pc and im remain usable; fetch_ctrl replaces pc in the fetch path.

Test Plan:
- Reset, START_ADDR=0, ack=req, inst_ready=1, im loaded from im_data.txt -> inst_pc 0,4,8 on consecutive cycles; inst 0x20000000, 0x20800000, 0x01000820.
- Hold inst_ready=0 for 3 cycles while inst_valid=1 -> inst, inst_pc and mem_addr unchanged; inst_ready=1 -> the next word is delivered and no word is skipped.
- Memory acks 3 cycles after req -> mem_addr stable throughout; inst_valid rises on the ack edge; inst_pc sequence stays 0,4,8.
- redirect_pc=0x43 pulsed while a read of 0x8 is pending (ack=0) -> S_DROP; the 0x8 data never appears on inst; next inst_pc=0x40.
- redirect while in S_HOLD with inst_ready=0 -> inst_valid drops the next cycle; the held word is never delivered.
- rst_n pulsed low mid-fetch -> outputs zero immediately (asynchronous), pc_out=START_ADDR; separately, START_ADDR=0xFFFFFFFC -> second inst_pc=0x00000000.
